// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer and its write-path arbiter:
// ROB depth, arbiter defaults and the arbiter's state encodings.
package rob_pkg;

  localparam int ROB_SIZE             = 16;
  localparam int DEF_DECODE_BURST     = 4;
  localparam int DEF_MAX_BCAST_CYCLES = ROB_SIZE;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_BCAST  = 2'd2;

endpackage

// File: rtl/rob_write_arbiter.sv
// Shares the ROB's single write port between decode allocation and the
// execution broadcast bus, locking the port for multi-cycle broadcasts.
module rob_write_arbiter
  import rob_pkg::*;
#(
  parameter int DECODE_BURST     = DEF_DECODE_BURST,
  parameter int MAX_BCAST_CYCLES = DEF_MAX_BCAST_CYCLES,
  parameter int CNT_WIDTH        = $clog2(MAX_BCAST_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt,
  input  logic       decodeValid,
  input  logic       robFull,
  input  logic       broadcastDataAvailable,
  input  logic       ongoingBroadcast,
  output logic       allowDecode,
  output logic       allowBroadcast,
  output logic       decodeStall,
  output logic       broadcastAck,
  output logic       broadcastTimeout,
  output logic [1:0] dbg_state_o
);

  // Handshake: the broadcaster holds broadcastDataAvailable until it sees a
  // one-cycle broadcastAck and may change its data on the following cycle;
  // decode holds its instruction while decodeStall is high.

  localparam logic [CNT_WIDTH-1:0] BURST_LIM = CNT_WIDTH'(DECODE_BURST);
  localparam logic [CNT_WIDTH-1:0] BCAST_LIM = CNT_WIDTH'(MAX_BCAST_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] dec_run_q, dec_run_d;
  logic [CNT_WIDTH-1:0] bcast_cnt_q, bcast_cnt_d;
  logic                 timeout_q, timeout_d;

  logic dec_req, bc_req;
  logic grant_dec, grant_bc, ack, fire;

  assign dec_req = decodeValid & ~robFull;
  assign bc_req  = broadcastDataAvailable;

  always_comb begin
    state_d     = state_q;
    dec_run_d   = dec_run_q;
    bcast_cnt_d = bcast_cnt_q;
    timeout_d   = timeout_q;
    grant_dec   = 1'b0;
    grant_bc    = 1'b0;
    ack         = 1'b0;
    fire        = 1'b0;
    if (!rst && !halt) begin
      if (state_q == ST_BCAST) begin
        if (!bc_req) begin
          state_d = ST_IDLE;
        end else begin
          grant_bc    = 1'b1;
          bcast_cnt_d = bcast_cnt_q + CNT_ONE;
          if (!ongoingBroadcast) begin
            ack     = 1'b1;
            state_d = dec_req ? ST_DECODE : ST_IDLE;
          // The limit counts grant cycles including this one.
          end else if (bcast_cnt_d == BCAST_LIM) begin
            ack       = 1'b1;
            fire      = 1'b1;
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end else if (bc_req && (!dec_req || dec_run_q == BURST_LIM)) begin
        grant_bc  = 1'b1;
        dec_run_d = '0;
        if (ongoingBroadcast) begin
          state_d     = ST_BCAST;
          bcast_cnt_d = CNT_ONE;
        end else begin
          ack     = 1'b1;
          state_d = dec_req ? ST_DECODE : ST_IDLE;
        end
      end else if (dec_req) begin
        grant_dec = 1'b1;
        state_d   = ST_DECODE;
        if (!bc_req)                    dec_run_d = '0;
        else if (dec_run_q < BURST_LIM) dec_run_d = dec_run_q + CNT_ONE;
      end else begin
        state_d   = ST_IDLE;
        dec_run_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dec_run_q   <= '0;
      bcast_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_run_q   <= dec_run_d;
      bcast_cnt_q <= bcast_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign allowDecode      = grant_dec;
  assign allowBroadcast   = grant_bc;
  assign broadcastAck     = ack;
  assign decodeStall      = decodeValid & ~grant_dec;
  assign broadcastTimeout = ~rst & (timeout_q | fire);
  assign dbg_state_o      = state_q;

endmodule

// File: doc/rob_write_arbiter.md
# rob_write_arbiter

Arbitration unit that shares the reorder buffer's single write path between the decode stage, which allocates new entries, and the execution broadcast bus, which fills pending source operands. Each cycle it drives exactly one of `allowDecode` or `allowBroadcast` (or neither). It holds a broadcast grant across the multiple cycles the ROB needs to fill every matching entry, acknowledges the broadcaster when done, and bounds starvation in both directions. It sits between the decode pipeline register, the execution broadcast bus and the ROB.

## Interface
- `DECODE_BURST`, default 4: max consecutive decode grants while a broadcast is waiting.
- `MAX_BCAST_CYCLES`, default 16 (= ROB_SIZE): watchdog limit on one broadcast's grant duration.
- `CNT_WIDTH`, default `$clog2(MAX_BCAST_CYCLES)+1`: width of the internal counters.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `halt` in 1: global stall.
- `decodeValid` in 1: decode presents a valid instruction (R/I/S-type OR).
- `robFull` in 1: ROB full flag.
- `broadcastDataAvailable` in 1: broadcaster holds a tag/data pair; held until acked.
- `ongoingBroadcast` in 1: ROB still has ≥1 entry matching the broadcast tag.
- `allowDecode` out 1: ROB may write decode data this cycle.
- `allowBroadcast` out 1: ROB may write broadcast data this cycle.
- `decodeStall` out 1: `decodeValid & ~allowDecode`; decode holds its instruction.
- `broadcastAck` out 1: one-cycle pulse; broadcaster may drop or replace its data next cycle.
- `broadcastTimeout` out 1: sticky error flag; the watchdog fired.

## Operation
- Request terms: `decReq = decodeValid & ~robFull`, `bcReq = broadcastDataAvailable`.
- State register has three states: IDLE, DECODE, BCAST. Counters: `decodeRun` (saturating at `DECODE_BURST`) and `bcastCycles`.
- IDLE / DECODE:
  - If `bcReq & (~decReq | decodeRun == DECODE_BURST)`: assert `allowBroadcast` and clear `decodeRun`. If `ongoingBroadcast` is high, go to BCAST with `bcastCycles = 1`. Otherwise assert `broadcastAck` this cycle (zero-match broadcast), then go to DECODE if `decReq`, else IDLE.
  - Else if `decReq`: assert `allowDecode` and go to DECODE. Increment `decodeRun` if `bcReq`, else clear it.
  - Else: go to IDLE and clear `decodeRun`.
- BCAST (locked; decode is never granted here):
  - `allowBroadcast = 1` and `bcastCycles` increments.
  - If `~ongoingBroadcast`: assert `broadcastAck`, then go to DECODE if `decReq` (decode gets the next turn), else IDLE.
  - Else if `bcastCycles == MAX_BCAST_CYCLES`: assert `broadcastAck` and set `broadcastTimeout`, then go to IDLE.
  - If `bcReq` drops while in BCAST (protocol violation): go to IDLE with no ack and no grant.
- `allowDecode` and `allowBroadcast` are mutually exclusive in every cycle.
- `halt`: all outputs 0 except `broadcastTimeout` and `decodeStall` (which follows `decodeValid`). State and counters hold.
- `robFull` blocks decode grants only; broadcasts continue.

## Timing
- Grants, ack and stall are combinational from registered state plus the current inputs (Mealy), so the ROB sees them in the same cycle. State and counters update on `posedge clk`.
- Reset (cycle of `rst` high): state IDLE, counters 0, `broadcastTimeout` 0, and `allowDecode`, `allowBroadcast`, `broadcastAck` forced to 0. `decodeStall` equals `decodeValid`.
- Reset mid-broadcast: the broadcast is abandoned without an ack; the broadcaster retries after reset.
- A decode grant occurs in the same cycle `decReq` rises if no broadcast is eligible.
- A broadcast matching N>0 entries produces `allowBroadcast` for N+1 cycles, with `broadcastAck` on cycle N+1. For N=0, ack comes on the grant cycle.
- Worst-case broadcast wait is `DECODE_BURST` decode cycles. Worst-case decode wait is one full broadcast (≤ `MAX_BCAST_CYCLES` cycles).
- `decodeRun` saturates and never wraps. `bcastCycles` is cleared on every entry to BCAST.

## Structure
- Shared package/include `rob_pkg`: state encodings (IDLE=0, DECODE=1, BCAST=2), default `DECODE_BURST` and `MAX_BCAST_CYCLES`, and `ROB_SIZE` (shared with the ROB).
- Single module with no sub-modules; the counters are small inline registers.

## Test plan
- Decode only: `decodeValid=1` for 5 cycles with no broadcast → `allowDecode=1` for all 5 cycles, `decodeStall=0`.
- Broadcast matching 3 entries, no decode → `allowBroadcast` for 4 cycles, `broadcastAck` on cycle 4, then IDLE.
- Continuous decode plus pending broadcast (`DECODE_BURST=4`) → 4 decode grants, then 1 broadcast grant (zero match, ack same cycle), then decode resumes.
- `robFull=1` with `decodeValid=1` and `bcReq` matching 2 entries → broadcast granted for 3 cycles, `decodeStall=1` throughout, `allowDecode` never asserted.
- `ongoingBroadcast` stuck at 1 → ack and `broadcastTimeout=1` on cycle 16; the flag stays set until `rst`.
- `rst` asserted on cycle 2 of a 5-entry broadcast → no ack, all grants 0 the next cycle, IDLE. `halt` mid-broadcast freezes the state, and the broadcast resumes where it stopped.
